// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, controller states, default iteration count and a magnitude helper.
package mdu_pkg;

    localparam int unsigned ITER_DEFAULT = 32;
    localparam int unsigned DATA_W       = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIN  = 2'b10
    } mdu_state_e;

    // Magnitude of a 32-bit operand; 32'h80000000 maps to itself, which is
    // the correct unsigned magnitude 2^31.
    function automatic logic [31:0] mdu_abs(input logic [31:0] val, input logic is_signed);
        logic [31:0] res;
        if (is_signed && val[31]) begin
            res = ~val + 32'd1;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit. One radix-2 step per cycle using a
// single 64-bit shift register and one 33-bit adder shared by shift-add
// multiply and restoring division. Signs are stripped on entry and restored
// in the FIN cycle, when HI/LO are written and done_o pulses.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned ITER = ITER_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    input  logic        hi_we_i,
    input  logic        lo_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int unsigned CNT_W = $clog2(ITER + 1);

    mdu_state_e       r_state;
    mdu_state_e       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [63:0]      r_acc;      // {HI part, LO part}: product or {remainder, quotient}
    logic [31:0]      r_mcand;    // multiplicand or divisor magnitude
    logic [31:0]      r_src1;     // raw dividend, returned in HI on divide by zero
    logic             r_is_div;
    logic             r_neg_q;    // negate product / quotient
    logic             r_neg_r;    // negate remainder
    logic             r_div0;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic             r_done;

    logic             w_last;
    logic             w_is_signed;
    logic             w_is_div;
    logic [31:0]      w_mag1;
    logic [31:0]      w_mag2;
    logic [32:0]      w_add_a;
    logic [32:0]      w_add_b;
    logic             w_add_cin;
    logic [32:0]      w_sum;
    logic [63:0]      w_step;
    logic [63:0]      w_prod_neg;
    logic [31:0]      w_quot;
    logic [31:0]      w_rem;
    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;

    assign w_last      = (r_cnt == CNT_W'(ITER - 1));
    assign w_is_signed = ~op_i[0];
    assign w_is_div    = op_i[1];
    assign w_mag1      = mdu_abs(src1_i, w_is_signed);
    assign w_mag2      = mdu_abs(src2_i, w_is_signed);

    // Controller state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: IDLE -> CALC on start, CALC for ITER edges, FIN for one.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_next = ST_CALC;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (w_last) begin
                    w_state_next = ST_FIN;
                end else begin
                    w_state_next = ST_CALC;
                end
            end
            ST_FIN:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Shared 33-bit adder: add multiplicand when LSB set, or subtract divisor
    // from the left-shifted partial remainder.
    always_comb begin
        w_add_a   = 33'd0;
        w_add_b   = 33'd0;
        w_add_cin = 1'b0;
        if (r_is_div) begin
            w_add_a   = r_acc[63:31];
            w_add_b   = ~{1'b0, r_mcand};
            w_add_cin = 1'b1;
        end else begin
            w_add_a   = {1'b0, r_acc[63:32]};
            w_add_b   = r_acc[0] ? {1'b0, r_mcand} : 33'd0;
            w_add_cin = 1'b0;
        end
        w_sum = w_add_a + w_add_b + {32'd0, w_add_cin};
    end

    // Next shift-register value for one iteration. For divide the partial
    // remainder is below the divisor, so the 33-bit difference sign is exact.
    always_comb begin
        w_step = r_acc;
        if (r_is_div) begin
            if (!w_sum[32]) begin
                w_step = {w_sum[31:0], r_acc[30:0], 1'b1};
            end else begin
                w_step = {r_acc[62:0], 1'b0};
            end
        end else begin
            w_step = {w_sum, r_acc[31:1]};
        end
    end

    // Sign correction and divide-by-zero substitution for the final write.
    always_comb begin
        w_prod_neg = ~r_acc + 64'd1;
        w_quot     = r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
        w_rem      = r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
        w_res_hi   = r_acc[63:32];
        w_res_lo   = r_acc[31:0];
        if (r_div0) begin
            w_res_hi = r_src1;
            w_res_lo = 32'hFFFF_FFFF;
        end else if (r_is_div) begin
            w_res_hi = w_rem;
            w_res_lo = w_quot;
        end else if (r_neg_q) begin
            w_res_hi = w_prod_neg[63:32];
            w_res_lo = w_prod_neg[31:0];
        end else begin
            w_res_hi = r_acc[63:32];
            w_res_lo = r_acc[31:0];
        end
    end

    // Datapath, HI/LO and done pulse. Start beats MTHI/MTLO in IDLE; writes
    // are ignored while busy; HI/LO only change in FIN or on a write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt    <= '0;
            r_acc    <= 64'd0;
            r_mcand  <= 32'd0;
            r_src1   <= 32'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_cnt    <= '0;
                        r_is_div <= w_is_div;
                        r_src1   <= src1_i;
                        r_div0   <= w_is_div & (src2_i == 32'd0);
                        r_neg_q  <= w_is_signed & (src1_i[31] ^ src2_i[31]);
                        r_neg_r  <= w_is_signed & src1_i[31];
                        if (w_is_div) begin
                            r_acc   <= {32'd0, w_mag1};
                            r_mcand <= w_mag2;
                        end else begin
                            r_acc   <= {32'd0, w_mag2};
                            r_mcand <= w_mag1;
                        end
                    end else begin
                        if (hi_we_i) begin
                            r_hi <= wdata_i;
                        end
                        if (lo_we_i) begin
                            r_lo <= wdata_i;
                        end
                    end
                end
                ST_CALC: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                ST_FIN: begin
                    r_hi   <= w_res_hi;
                    r_lo   <= w_res_lo;
                    r_done <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign hi_o   = r_hi;
    assign lo_o   = r_lo;
    assign done_o = r_done;
    assign busy_o = (r_state != ST_IDLE);

endmodule
